dnpcie_aurora_link_monitor: RTL

- Supervises a running Aurora link in the init_clk domain and sits directly upstream of the Aurora reset sequencer.
- Issues its ext_reset request and supplies its 48-bit hotplug_wait value.
- Requests a reset on channel-up timeout, debounced channel drop, hard error or software request.
- Applies exponential backoff to the hotplug wait across consecutive failed bring-ups.

---
 rtl/dnpcie_aurora_link_monitor_pkg.sv | 33 +++
 rtl/dnpcie_sync_ff.sv | 23 ++
 rtl/dnpcie_aurora_link_monitor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dnpcie_aurora_link_monitor_pkg.sv
// Shared definitions for the Aurora link monitor: FSM encoding and hotplug word layout.
// No logic of its own; the helper functions are pure combinational.
// Nothing in this file carries state or applies backpressure.
package dnpcie_aurora_link_monitor_pkg;

    typedef enum logic [2:0] {
        WAIT_READY = 3'd0,
        WAIT_UP    = 3'd1,
        LINK_UP    = 3'd2,
        REQ        = 3'd3,
        REQ_ACK    = 3'd4
    } state_t;

    localparam logic [15:0] HOTPLUG_LOW_ONES = 16'hFFFF;
    localparam int          HP_FIELD_LSB     = 16;
    localparam int          HP_FIELD_MSB     = 31;

    // Shift is done 32 bits wide so a large backoff clamps instead of wrapping.
    function automatic logic [15:0] hp_mult(input logic [15:0] base, input logic [3:0] shift);
        logic [31:0] wide;
        wide = {16'h0, base} << shift;
        return (wide > 32'h0000_FFFF) ? 16'hFFFF : wide[15:0];
    endfunction

    function automatic logic [47:0] hp_word(input logic [15:0] mult);
        logic [47:0] word;
        word = '0;
        word[HP_FIELD_MSB:HP_FIELD_LSB] = mult;
        word[15:0] = HOTPLUG_LOW_ONES;
        return word;
    endfunction

endpackage

// File: rtl/dnpcie_sync_ff.sv
// Two-flop synchronizer for a single asynchronous level, resetting to 0.
// Latency: 2 clk_i edges (2-3 cycles from an arbitrary input edge).
// No backpressure; pure level transfer.
module dnpcie_sync_ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [1:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ff_q <= 2'b00;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/dnpcie_aurora_link_monitor.sv
// Supervises an Aurora link and requests resets from the sequencer with exponential hotplug backoff.
// Latency: channel_up to link_ok 3 cycles; request decision to ext_reset_o 1 cycle (registered).
// Backpressure: ext_reset_o is a level held until reset_busy_i acknowledges; no timeout.
module dnpcie_aurora_link_monitor
    import dnpcie_aurora_link_monitor_pkg::*;
#(
    parameter logic [31:0] UP_TIMEOUT    = 32'd200000000,
    parameter logic [15:0] DROP_DEBOUNCE = 16'd1000,
    parameter logic [15:0] HP_BASE       = 16'd3,
    parameter logic [3:0]  MAX_BACKOFF   = 4'd5
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        channel_up_i,
    input  logic        hard_err_i,
    input  logic        sw_reset_i,
    input  logic        reset_busy_i,
    output logic        ext_reset_o,
    output logic [47:0] hotplug_wait_o,
    output logic        link_ok_o,
    output logic [3:0]  fail_count_o,
    output logic [15:0] reset_count_o
);

    logic up_s;
    logic err_s;

    dnpcie_sync_ff u_sync_up (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (channel_up_i),
        .q_o     (up_s)
    );

    dnpcie_sync_ff u_sync_err (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (hard_err_i),
        .q_o     (err_s)
    );

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [15:0] drop_q, drop_d;
    logic [3:0]  fail_q, fail_d;
    logic [15:0] reset_cnt_q;
    logic [47:0] hp_q;
    logic        ext_q;
    logic        link_ok_q;
    logic        req_entry;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        drop_d  = drop_q;
        fail_d  = fail_q;
        case (state_q)
            WAIT_READY: begin
                if (!reset_busy_i) begin
                    state_d = WAIT_UP;
                    timer_d = '0;
                end
            end
            WAIT_UP: begin
                timer_d = timer_q + 32'd1;
                if (err_s || sw_reset_i) begin
                    state_d = REQ;
                end else if (up_s) begin
                    state_d = LINK_UP;
                    fail_d  = '0;
                    drop_d  = '0;
                end else if (timer_q == UP_TIMEOUT - 32'd1) begin
                    // Only an unassisted timeout counts as a failed bring-up.
                    state_d = REQ;
                    fail_d  = (fail_q >= MAX_BACKOFF) ? MAX_BACKOFF : fail_q + 4'd1;
                end else if (reset_busy_i) begin
                    state_d = WAIT_READY;
                end
            end
            LINK_UP: begin
                drop_d = up_s ? 16'd0 : drop_q + 16'd1;
                if (err_s || sw_reset_i || (!up_s && drop_q == DROP_DEBOUNCE - 16'd1)) begin
                    state_d = REQ;
                end else if (reset_busy_i) begin
                    state_d = WAIT_READY;
                end
            end
            REQ: begin
                if (reset_busy_i) begin
                    state_d = REQ_ACK;
                end
            end
            REQ_ACK: begin
                if (!reset_busy_i) begin
                    state_d = WAIT_UP;
                    timer_d = '0;
                end
            end
            default: state_d = WAIT_READY;
        endcase
    end

    assign req_entry = (state_d == REQ) && (state_q != REQ);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= WAIT_READY;
            timer_q     <= '0;
            drop_q      <= '0;
            fail_q      <= '0;
            reset_cnt_q <= '0;
            hp_q        <= hp_word(HP_BASE);
            ext_q       <= 1'b0;
            link_ok_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            drop_q    <= drop_d;
            fail_q    <= fail_d;
            ext_q     <= (state_d == REQ);
            link_ok_q <= (state_d == LINK_UP);
            // Hotplug word moves only here so the sequencer always latches a stable value.
            if (req_entry) begin
                if (reset_cnt_q != 16'hFFFF) begin
                    reset_cnt_q <= reset_cnt_q + 16'd1;
                end
                hp_q <= hp_word(hp_mult(HP_BASE, fail_d));
            end
        end
    end

    assign ext_reset_o    = ext_q;
    assign hotplug_wait_o = hp_q;
    assign link_ok_o      = link_ok_q;
    assign fail_count_o   = fail_q;
    assign reset_count_o  = reset_cnt_q;

endmodule
